// File: rtl/ppl_dispatch.sv
// rtl/ppl_dispatch.sv - raymarch pipeline dispatch: recirculated rays first, then raster-scanned primary rays
// Single-entry output register; in-flight counter throttles primary rays and detects frame completion.
module ppl_dispatch #(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 720,
  parameter int POS_W        = 16,
  parameter int SLOPE_W      = 20,
  parameter int CNT_W        = 4,
  parameter int SCALE_SH     = 7,
  parameter int MAX_INFLIGHT = 64,
  parameter int ADDR_W       = $clog2(H_DISP*V_DISP),
  parameter int IF_W         = $clog2(MAX_INFLIGHT+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [POS_W-1:0]   cam_pos_x,
  input  logic [POS_W-1:0]   cam_pos_y,
  input  logic [POS_W-1:0]   cam_pos_z,
  input  logic [SLOPE_W-1:0] vp_origin_x,
  input  logic [SLOPE_W-1:0] vp_origin_y,
  input  logic [SLOPE_W-1:0] vp_origin_z,
  input  logic [SLOPE_W-1:0] vp_u_x,
  input  logic [SLOPE_W-1:0] vp_u_y,
  input  logic [SLOPE_W-1:0] vp_u_z,
  input  logic [SLOPE_W-1:0] vp_v_x,
  input  logic [SLOPE_W-1:0] vp_v_y,
  input  logic [SLOPE_W-1:0] vp_v_z,
  input  logic               rec_valid,
  output logic               rec_ready,
  input  logic [POS_W-1:0]   rec_pos_x,
  input  logic [POS_W-1:0]   rec_pos_y,
  input  logic [POS_W-1:0]   rec_pos_z,
  input  logic [SLOPE_W-1:0] rec_slope_x,
  input  logic [SLOPE_W-1:0] rec_slope_y,
  input  logic [SLOPE_W-1:0] rec_slope_z,
  input  logic [CNT_W-1:0]   rec_cnt,
  input  logic [ADDR_W-1:0]  rec_addr,
  input  logic               ray_retire,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POS_W-1:0]   out_pos_x,
  output logic [POS_W-1:0]   out_pos_y,
  output logic [POS_W-1:0]   out_pos_z,
  output logic [SLOPE_W-1:0] out_slope_x,
  output logic [SLOPE_W-1:0] out_slope_y,
  output logic [SLOPE_W-1:0] out_slope_z,
  output logic [CNT_W-1:0]   out_cnt,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [IF_W-1:0]    in_flight,
  output logic               busy,
  output logic               frame_done
);

  localparam int X_W  = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int Y_W  = (V_DISP > 1) ? $clog2(V_DISP) : 1;
  localparam int UV_W = 13;
  localparam int PR_W = SLOPE_W + UV_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IF_W-1:0]    in_flight_q, in_flight_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [POS_W-1:0]   opx_q, opx_d, opy_q, opy_d, opz_q, opz_d;
  logic [SLOPE_W-1:0] osx_q, osx_d, osy_q, osy_d, osz_q, osz_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic [ADDR_W-1:0]  oaddr_q, oaddr_d;
  logic [POS_W-1:0]   cpx_q, cpx_d, cpy_q, cpy_d, cpz_q, cpz_d;
  logic [SLOPE_W-1:0] vox_q, vox_d, voy_q, voy_d, voz_q, voz_d;
  logic [SLOPE_W-1:0] vux_q, vux_d, vuy_q, vuy_d, vuz_q, vuz_d;
  logic [SLOPE_W-1:0] vvx_q, vvx_d, vvy_q, vvy_d, vvz_q, vvz_d;

  logic                    load, emit, retire_ok, last_x, last_y, can_issue;
  logic signed [UV_W-1:0]  uv_x, uv_y;

  // origin + ((u*uv_x - v*uv_y) >>> SCALE_SH), evaluated wide then truncated
  function automatic logic [SLOPE_W-1:0] calc_slope(
    input logic [SLOPE_W-1:0] org,
    input logic [SLOPE_W-1:0] u,
    input logic [SLOPE_W-1:0] v,
    input logic [UV_W-1:0]    ux,
    input logic [UV_W-1:0]    uy
  );
    logic signed [PR_W-1:0] oe, ue, ve, xe, ye, sum;
    oe  = {{UV_W{org[SLOPE_W-1]}}, org};
    ue  = {{UV_W{u[SLOPE_W-1]}}, u};
    ve  = {{UV_W{v[SLOPE_W-1]}}, v};
    xe  = {{SLOPE_W{ux[UV_W-1]}}, ux};
    ye  = {{SLOPE_W{uy[UV_W-1]}}, uy};
    sum = ue * xe - ve * ye;
    sum = (sum >>> SCALE_SH) + oe;
    return sum[SLOPE_W-1:0];
  endfunction

  assign uv_x      = {{(UV_W-X_W){1'b0}}, x_q} - UV_W'(H_DISP/2);
  assign uv_y      = {{(UV_W-Y_W){1'b0}}, y_q} - UV_W'(V_DISP/2);
  assign last_x    = (x_q == X_W'(H_DISP-1));
  assign last_y    = (y_q == Y_W'(V_DISP-1));
  assign can_issue = (in_flight_q < IF_W'(MAX_INFLIGHT));
  assign load      = ~out_valid_q | out_ready;
  assign retire_ok = ray_retire & (in_flight_q != '0);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    in_flight_d  = in_flight_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    opx_d = opx_q;  opy_d = opy_q;  opz_d = opz_q;
    osx_d = osx_q;  osy_d = osy_q;  osz_d = osz_q;
    ocnt_d = ocnt_q;
    oaddr_d = oaddr_q;
    cpx_d = cpx_q;  cpy_d = cpy_q;  cpz_d = cpz_q;
    vox_d = vox_q;  voy_d = voy_q;  voz_d = voz_q;
    vux_d = vux_q;  vuy_d = vuy_q;  vuz_d = vuz_q;
    vvx_d = vvx_q;  vvy_d = vvy_q;  vvz_d = vvz_q;
    rec_ready = 1'b0;
    emit      = 1'b0;

    if (load) begin
      if (rec_valid) begin
        rec_ready   = ~rst;
        out_valid_d = 1'b1;
        opx_d = rec_pos_x;    opy_d = rec_pos_y;    opz_d = rec_pos_z;
        osx_d = rec_slope_x;  osy_d = rec_slope_y;  osz_d = rec_slope_z;
        ocnt_d  = rec_cnt;
        oaddr_d = rec_addr;
      end else if (state_q == S_RUN && can_issue) begin
        emit        = 1'b1;
        out_valid_d = 1'b1;
        opx_d = cpx_q;  opy_d = cpy_q;  opz_d = cpz_q;
        osx_d = calc_slope(vox_q, vux_q, vvx_q, uv_x, uv_y);
        osy_d = calc_slope(voy_q, vuy_q, vvy_q, uv_x, uv_y);
        osz_d = calc_slope(voz_q, vuz_q, vvz_q, uv_x, uv_y);
        ocnt_d  = '0;
        oaddr_d = addr_q;
        if (last_x) begin
          x_d = '0;
          y_d = last_y ? '0 : y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
        addr_d = (last_x && last_y) ? '0 : addr_q + ADDR_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (emit && !retire_ok)
      in_flight_d = in_flight_q + IF_W'(1);
    else if (!emit && retire_ok)
      in_flight_d = in_flight_q - IF_W'(1);

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_RUN;
          x_d = '0;  y_d = '0;  addr_d = '0;
          cpx_d = cam_pos_x;    cpy_d = cam_pos_y;    cpz_d = cam_pos_z;
          vox_d = vp_origin_x;  voy_d = vp_origin_y;  voz_d = vp_origin_z;
          vux_d = vp_u_x;       vuy_d = vp_u_y;       vuz_d = vp_u_z;
          vvx_d = vp_v_x;       vvy_d = vp_v_y;       vvz_d = vp_v_z;
        end
      end
      S_RUN: begin
        if (emit && last_x && last_y) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (in_flight_q == '0) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      in_flight_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      opx_q <= '0;  opy_q <= '0;  opz_q <= '0;
      osx_q <= '0;  osy_q <= '0;  osz_q <= '0;
      ocnt_q  <= '0;
      oaddr_q <= '0;
      cpx_q <= '0;  cpy_q <= '0;  cpz_q <= '0;
      vox_q <= '0;  voy_q <= '0;  voz_q <= '0;
      vux_q <= '0;  vuy_q <= '0;  vuz_q <= '0;
      vvx_q <= '0;  vvy_q <= '0;  vvz_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      in_flight_q  <= in_flight_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      opx_q <= opx_d;  opy_q <= opy_d;  opz_q <= opz_d;
      osx_q <= osx_d;  osy_q <= osy_d;  osz_q <= osz_d;
      ocnt_q  <= ocnt_d;
      oaddr_q <= oaddr_d;
      cpx_q <= cpx_d;  cpy_q <= cpy_d;  cpz_q <= cpz_d;
      vox_q <= vox_d;  voy_q <= voy_d;  voz_q <= voz_d;
      vux_q <= vux_d;  vuy_q <= vuy_d;  vuz_q <= vuz_d;
      vvx_q <= vvx_d;  vvy_q <= vvy_d;  vvz_q <= vvz_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pos_x   = opx_q;
  assign out_pos_y   = opy_q;
  assign out_pos_z   = opz_q;
  assign out_slope_x = osx_q;
  assign out_slope_y = osy_q;
  assign out_slope_z = osz_q;
  assign out_cnt     = ocnt_q;
  assign out_addr    = oaddr_q;
  assign in_flight   = in_flight_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ppl_dispatch.sv
// tb/tb_ppl_dispatch.sv - randomized scoreboard bench for ppl_dispatch on a 4x2 frame, 3 rays in flight
module tb_ppl_dispatch;
  localparam int H_T = 4;
  localparam int V_T = 2;
  localparam int NPIX = H_T * V_T;
  localparam int MAXI = 3;
  localparam int AW = 3;
  localparam int IW = 2;

  typedef struct packed {
    logic [15:0] px, py, pz;
    logic [19:0] sx, sy, sz;
    logic [3:0]  cnt;
    logic [AW-1:0] addr;
  } ray_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0, rec_valid = 1'b0, out_ready = 1'b0, ray_retire = 1'b0;
  logic rec_ready, out_valid, busy, frame_done;
  logic [15:0] rec_pos_x = '0, rec_pos_y = '0, rec_pos_z = '0;
  logic [19:0] rec_slope_x = '0, rec_slope_y = '0, rec_slope_z = '0;
  logic [3:0]  rec_cnt = '0;
  logic [AW-1:0] rec_addr = '0;
  logic [15:0] out_pos_x, out_pos_y, out_pos_z;
  logic [19:0] out_slope_x, out_slope_y, out_slope_z;
  logic [3:0]  out_cnt;
  logic [AW-1:0] out_addr;
  logic [IW-1:0] in_flight;

  logic [15:0] cp [3];
  int vo [3];
  int vu [3];
  int vv [3];

  always #5 clk = ~clk;

  ppl_dispatch #(
    .H_DISP(H_T), .V_DISP(V_T), .POS_W(16), .SLOPE_W(20), .CNT_W(4),
    .SCALE_SH(7), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .cam_pos_x(cp[0]), .cam_pos_y(cp[1]), .cam_pos_z(cp[2]),
    .vp_origin_x(20'(vo[0])), .vp_origin_y(20'(vo[1])), .vp_origin_z(20'(vo[2])),
    .vp_u_x(20'(vu[0])), .vp_u_y(20'(vu[1])), .vp_u_z(20'(vu[2])),
    .vp_v_x(20'(vv[0])), .vp_v_y(20'(vv[1])), .vp_v_z(20'(vv[2])),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_pos_x(rec_pos_x), .rec_pos_y(rec_pos_y), .rec_pos_z(rec_pos_z),
    .rec_slope_x(rec_slope_x), .rec_slope_y(rec_slope_y), .rec_slope_z(rec_slope_z),
    .rec_cnt(rec_cnt), .rec_addr(rec_addr), .ray_retire(ray_retire),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos_x(out_pos_x), .out_pos_y(out_pos_y), .out_pos_z(out_pos_z),
    .out_slope_x(out_slope_x), .out_slope_y(out_slope_y), .out_slope_z(out_slope_z),
    .out_cnt(out_cnt), .out_addr(out_addr), .in_flight(in_flight),
    .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;
  ray_t exp_q[$];
  ray_t mon_got, mon_exp;

  // reference model: frame phase (0 idle, 1 scanning, 2 draining), next pixel index, rays in pipeline
  int m_state, m_p, m_inf;
  bit m_ov, m_done;
  bit fix_vp = 1'b0;
  logic [15:0] l_cp [3];
  int l_vo [3];
  int l_vu [3];
  int l_vv [3];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [19:0] ref_slope(input int org, input int u, input int v, input int p);
    longint ux, uy, s;
    ux = longint'(p % H_T) - H_T / 2;
    uy = longint'(p / H_T) - V_T / 2;
    s  = longint'(u) * ux - longint'(v) * uy;
    s  = s >>> 7;
    s  = s + longint'(org);
    return s[19:0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_p = 0; m_inf = 0; m_ov = 1'b0; m_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; rec_valid = 1'b0; out_ready = 1'b0; ray_retire = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input bit fs, input bit rv, input bit rdy, input bit ret);
    bit load, racc, emit;
    ray_t r;
    frame_start = fs; rec_valid = rv; out_ready = rdy; ray_retire = ret;
    rec_pos_x = 16'($urandom); rec_pos_y = 16'($urandom); rec_pos_z = 16'($urandom);
    rec_slope_x = 20'($urandom); rec_slope_y = 20'($urandom); rec_slope_z = 20'($urandom);
    rec_cnt = 4'($urandom); rec_addr = AW'($urandom);
    if (!fix_vp) begin
      for (int i = 0; i < 3; i++) begin
        cp[i] = 16'($urandom);
        vo[i] = int'($urandom_range(0, 262143)) - 131072;
        vu[i] = int'($urandom_range(0, 262143)) - 131072;
        vv[i] = int'($urandom_range(0, 262143)) - 131072;
      end
    end
    #1;
    load = !m_ov || rdy;
    racc = load && rv;
    emit = load && !rv && m_state == 1 && m_inf < MAXI;
    chk("rec_ready", longint'(rec_ready), longint'(racc));
    if (racc) begin
      r = '{rec_pos_x, rec_pos_y, rec_pos_z, rec_slope_x, rec_slope_y, rec_slope_z, rec_cnt, rec_addr};
      exp_q.push_back(r);
    end else if (emit) begin
      r.px = l_cp[0]; r.py = l_cp[1]; r.pz = l_cp[2];
      r.sx = ref_slope(l_vo[0], l_vu[0], l_vv[0], m_p);
      r.sy = ref_slope(l_vo[1], l_vu[1], l_vv[1], m_p);
      r.sz = ref_slope(l_vo[2], l_vu[2], l_vv[2], m_p);
      r.cnt = '0;
      r.addr = AW'(m_p);
      exp_q.push_back(r);
    end
    if (load) m_ov = racc || emit;
    m_done = (m_state == 2 && m_inf == 0);
    case (m_state)
      0: if (fs) begin
        m_state = 1; m_p = 0;
        for (int i = 0; i < 3; i++) begin
          l_cp[i] = cp[i]; l_vo[i] = vo[i]; l_vu[i] = vu[i]; l_vv[i] = vv[i];
        end
      end
      1: if (emit) begin
        if (m_p == NPIX - 1) m_state = 2;
        m_p++;
      end
      default: if (m_inf == 0) m_state = 0;
    endcase
    m_inf = m_inf + (emit ? 1 : 0) - ((ret && m_inf > 0) ? 1 : 0);
    @(posedge clk); #1;
    chk("in_flight", longint'(in_flight), longint'(m_inf));
    chk("busy", longint'(busy), longint'(m_state != 0));
    chk("frame_done", longint'(frame_done), longint'(m_done));
    chk("out_valid", longint'(out_valid), longint'(m_ov));
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got = '{out_pos_x, out_pos_y, out_pos_z, out_slope_x, out_slope_y, out_slope_z, out_cnt, out_addr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ray_unexpected: got %h required none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL ray: got %h required %h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin cp[i] = '0; vo[i] = 0; vu[i] = 0; vv[i] = 0; end
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_rec_ready", longint'(rec_ready), 0);
    chk("rst_in_flight", longint'(in_flight), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_frame_done", longint'(frame_done), 0);
    chk("rst_out_addr", longint'(out_addr), 0);
    chk("rst_out_slope_x", longint'(out_slope_x), 0);

    // fixed basis: pixel x=0 gives slope_x -16, x=3 gives +8; throttles at 3 in flight
    fix_vp = 1'b1;
    vo[0] = 0; vo[1] = 0; vo[2] = 4096;
    vu[0] = 1024; vu[1] = 0; vu[2] = 0;
    vv[0] = 0; vv[1] = 0; vv[2] = 0;
    cycle(1, 0, 1, 0);
    fix_vp = 1'b0;
    repeat (6) cycle(0, 0, 1, 0);
    chk("throttle_in_flight", longint'(in_flight), MAXI);
    cycle(0, 0, 1, 1);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 40 && (m_state != 0 || m_inf != 0); i++) cycle(0, 0, 1, m_inf > 0);

    // recirculation owns the output while offered; then a stalled output must hold
    cycle(1, 0, 1, 0);
    repeat (20) cycle(0, 1, 1, 0);
    repeat (5) cycle(0, 1, 0, 0);
    repeat (5) cycle(0, 0, 0, 1);

    for (int n = 0; n < 1500; n++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

    for (int i = 0; i < 300 && (m_state != 0 || m_inf != 0 || m_ov); i++)
      cycle(0, 0, 1, m_inf > 0);
    chk("drain_busy", longint'(busy), 0);
    chk("drain_in_flight", longint'(in_flight), 0);
    cycle(0, 0, 1, 0);
    chk("queue_empty", longint'(exp_q.size()), 0);

    // reset in the middle of a frame returns everything to idle without frame_done
    cycle(1, 0, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);
    do_reset();
    chk("mid_rst_in_flight", longint'(in_flight), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    repeat (3) cycle(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
